// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with selectable bit order, shift pause and
// back-to-back frame loading on the last bit of the current frame.
module piso_serializer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             dir,
    input  logic             en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dir;
    logic               r_done;
    logic               w_serial_valid;
    logic               w_last;
    logic               w_load_ready;
    logic               w_load;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake decode; a frame may reload on its own last bit
    always_comb begin
        w_state_nxt    = r_state;
        w_serial_valid = 1'b0;
        w_last         = 1'b0;
        w_load_ready   = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            IDLE: begin
                w_load_ready = 1'b1;
                w_load       = load_valid;
                if (w_load) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_serial_valid = en;
                w_last         = en && (r_cnt == CNT_W'(WIDTH - 1));
                w_load_ready   = w_last;
                w_load         = load_valid && w_last;
                if (w_last && !w_load) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shift register, bit counter, latched order and registered done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_shift <= load_data;
                r_dir   <= dir;
                r_cnt   <= '0;
            end else if (w_serial_valid) begin
                if (r_dir) begin
                    r_shift <= {1'b0, r_shift[WIDTH-1:1]};
                end else begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                end
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign load_ready   = w_load_ready;
    assign serial_valid = w_serial_valid;
    assign last         = w_last;
    assign busy         = (r_state == SHIFT);
    assign done         = r_done;
    assign serial_out   = (r_state == SHIFT) ? (r_dir ? r_shift[0] : r_shift[WIDTH-1]) : 1'b0;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios then random traffic,
// compared against a queue-of-pending-bits reference model.
module tb_piso_serializer;

    localparam int unsigned W = 5;

    logic          clk;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_data;
    logic          dir;
    logic          en;
    logic          serial_out;
    logic          serial_valid;
    logic          last;
    logic          busy;
    logic          done;

    int            checks = 0;
    int            errors = 0;

    // Reference model: bits still to be sent for the active frame, plus done flag
    bit            mq[$];
    bit            m_done = 1'b0;

    // Collected serial bits (MSB = earliest) for frame-level checks
    logic [31:0]   acc;
    int            nacc;

    piso_serializer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .dir          (dir),
        .en           (en),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .last         (last),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        acc  = '0;
        nacc = 0;
    endtask

    // Apply inputs for one cycle, check outputs mid-cycle, advance the model at the edge
    task automatic cycle(input logic lv, input logic [W-1:0] d, input logic dr,
                         input logic e, input logic r);
        logic exp_busy;
        logic exp_sv;
        logic exp_last;
        logic exp_ready;
        logic exp_out;
        load_valid = lv;
        load_data  = d;
        dir        = dr;
        en         = e;
        rst        = r;
        @(negedge clk);
        exp_busy  = (mq.size() != 0);
        exp_sv    = exp_busy && e;
        exp_last  = exp_sv && (mq.size() == 1);
        exp_ready = !exp_busy || exp_last;
        exp_out   = exp_busy ? mq[0] : 1'b0;
        chk("busy",         32'(busy),         32'(exp_busy));
        chk("serial_valid", 32'(serial_valid), 32'(exp_sv));
        chk("last",         32'(last),         32'(exp_last));
        chk("load_ready",   32'(load_ready),   32'(exp_ready));
        chk("serial_out",   32'(serial_out),   32'(exp_out));
        chk("done",         32'(done),         32'(m_done));
        if (serial_valid === 1'b1) begin
            acc = {acc[30:0], serial_out};
            nacc++;
        end
        if (r) begin
            mq.delete();
            m_done = 1'b0;
        end else begin
            if (exp_sv) void'(mq.pop_front());
            if (lv && exp_ready) begin
                for (int i = 0; i < int'(W); i++) begin
                    mq.push_back(dr ? d[i] : d[int'(W) - 1 - i]);
                end
            end
            m_done = exp_last;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        dir        = 1'b0;
        en         = 1'b0;
        clear_acc();
        @(posedge clk);
        #1;
        cycle(1'b1, 5'b11111, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // MSB-first frame
        clear_acc();
        cycle(1'b1, 5'b10110, 1'b0, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("r031_bits", acc, 32'b10110);
        chk("r031_count", 32'(nacc), 32'd5);

        // LSB-first frame
        clear_acc();
        cycle(1'b1, 5'b10110, 1'b1, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("r032_bits", acc, 32'b01101);

        // Pause for two cycles after the second bit
        clear_acc();
        cycle(1'b1, 5'b11001, 1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("r033_bits", acc, 32'b11001);
        chk("r033_count", 32'(nacc), 32'd5);

        // Back-to-back frames with no gap
        clear_acc();
        cycle(1'b1, 5'b10000, 1'b0, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 5'b00001, 1'b0, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("r034_bits", acc, 32'b1000000001);
        chk("r034_count", 32'(nacc), 32'd10);

        // Loads offered mid-frame are refused
        clear_acc();
        cycle(1'b1, 5'b10110, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b1, 5'b11111, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("r035_bits", acc, 32'b10110);

        // Reset mid-frame, then a clean frame
        cycle(1'b1, 5'b10110, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        clear_acc();
        cycle(1'b1, 5'b01010, 1'b0, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("r036_bits", acc, 32'b01010);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
